fabosc_clkdiv_gen: RTL

//  Parametrised N-channel fabric clock generator fed by the RC oscillator fabric clock (50 MHz).

---
 rtl/fabosc_clkdiv_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fabosc_clkdiv_gen.sv
// N-channel fabric clock divider with glitch-free per-channel run/stop and a shared
// ratio write port; each new ratio lands on the target channel's period boundary.
module fabosc_clkdiv_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50,
    parameter int CH_W        = 2
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              DIV_WR,
    input  logic [CH_W-1:0]   DIV_CH,
    input  logic [DIV_W-1:0]  DIV_DATA,
    output logic              DIV_BUSY,
    output logic              DIV_ERR,
    output logic [NUM_CH-1:0] CLK_OUT,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] CH_ACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    state_t            r_state [NUM_CH];
    logic [DIV_W-1:0]  r_cnt   [NUM_CH];
    logic [DIV_W-1:0]  r_div   [NUM_CH];
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_active;

    logic              r_pend_vld;
    logic [CH_W-1:0]   r_pend_ch;
    logic [DIV_W-1:0]  r_pend_data;
    logic              r_err;

    state_t            w_state_n [NUM_CH];
    logic [DIV_W-1:0]  w_cnt_n   [NUM_CH];
    logic [DIV_W-1:0]  w_div_n   [NUM_CH];
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_apply;
    logic [NUM_CH-1:0] w_clk_n;
    logic [NUM_CH-1:0] w_tick_n;
    logic [NUM_CH-1:0] w_act_n;
    logic              w_req_valid;
    logic              w_wr_ok;
    logic              w_wr_bad;

    // Request validation for the shared write port.
    always_comb begin
        w_req_valid = (DIV_DATA >= TWO) &&
                      ({{(32-CH_W){1'b0}}, DIV_CH} < 32'(NUM_CH));
        w_wr_ok     = DIV_WR && !r_pend_vld && w_req_valid;
        w_wr_bad    = DIV_WR && !r_pend_vld && !w_req_valid;
    end

    // Per-channel next state, counter, ratio and the values the output flops will take.
    always_comb begin
        w_wrap   = '0;
        w_hit    = '0;
        w_apply  = '0;
        w_clk_n  = '0;
        w_tick_n = '0;
        w_act_n  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_n[i] = r_state[i];
            w_cnt_n[i]   = r_cnt[i];
            w_div_n[i]   = r_div[i];
            w_wrap[i]    = (r_cnt[i] == (r_div[i] - ONE));
            w_hit[i]     = r_pend_vld && (r_pend_ch == CH_W'(i));
            case (r_state[i])
                ST_IDLE: begin
                    w_cnt_n[i]   = '0;
                    w_apply[i]   = w_hit[i];
                    w_state_n[i] = CH_EN[i] ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    w_state_n[i] = CH_EN[i] ? ST_RUN : ST_STOP;
                    if (w_wrap[i]) begin
                        w_cnt_n[i] = '0;
                        w_apply[i] = w_hit[i];
                    end else begin
                        w_cnt_n[i] = r_cnt[i] + ONE;
                    end
                end
                ST_STOP: begin
                    // The period in flight always completes before the channel parks.
                    if (w_wrap[i]) begin
                        w_cnt_n[i]   = '0;
                        w_apply[i]   = w_hit[i];
                        w_state_n[i] = CH_EN[i] ? ST_RUN : ST_IDLE;
                    end else begin
                        w_cnt_n[i]   = r_cnt[i] + ONE;
                        w_state_n[i] = CH_EN[i] ? ST_RUN : ST_STOP;
                    end
                end
                default: begin
                    w_state_n[i] = ST_IDLE;
                    w_cnt_n[i]   = '0;
                    w_div_n[i]   = DEF_DIV;
                end
            endcase
            if (w_apply[i]) begin
                w_div_n[i] = r_pend_data;
            end else begin
                w_div_n[i] = w_div_n[i];
            end
            w_act_n[i]  = (w_state_n[i] != ST_IDLE);
            w_clk_n[i]  = w_act_n[i] && (w_cnt_n[i] < (w_div_n[i] >> 1));
            w_tick_n[i] = w_act_n[i] && (w_cnt_n[i] == (w_div_n[i] - ONE));
        end
    end

    // Channel state, counters, ratios and registered channel outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_div[i]   <= DEF_DIV;
            end
            r_clk_out <= '0;
            r_tick    <= '0;
            r_active  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_n[i];
                r_cnt[i]   <= w_cnt_n[i];
                r_div[i]   <= w_div_n[i];
            end
            r_clk_out <= w_clk_n;
            r_tick    <= w_tick_n;
            r_active  <= w_act_n;
        end
    end

    // Single pending-write slot and the reject pulse.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pend_vld  <= 1'b0;
            r_pend_ch   <= '0;
            r_pend_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_wr_bad;
            if (w_wr_ok) begin
                r_pend_vld  <= 1'b1;
                r_pend_ch   <= DIV_CH;
                r_pend_data <= DIV_DATA;
            end else if (|w_apply) begin
                r_pend_vld  <= 1'b0;
            end else begin
                r_pend_vld  <= r_pend_vld;
            end
        end
    end

    assign DIV_BUSY  = r_pend_vld;
    assign DIV_ERR   = r_err;
    assign CLK_OUT   = r_clk_out;
    assign TICK      = r_tick;
    assign CH_ACTIVE = r_active;

endmodule
